fpdiv_normround: RTL and testbench

//  Post-divider normalise/round stage for the radix-16 floating-point divider.

---
 rtl/fpdiv_pkg.sv | 34 +++
 rtl/fpdiv_normround_if.sv | 35 +++
 rtl/fpdiv_round.sv | 27 ++
 rtl/fpdiv_normround.sv | 166 ++++++++++++++++
 tb/tb_fpdiv_normround.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpdiv_pkg.sv
// rtl/fpdiv_pkg.sv - shared round modes, FSM encoding and flag indices for the divider back end
package fpdiv_pkg;

    localparam logic [2:0] RM_RNE = 3'd0;
    localparam logic [2:0] RM_RTZ = 3'd1;
    localparam logic [2:0] RM_RDN = 3'd2;
    localparam logic [2:0] RM_RUP = 3'd3;
    localparam logic [2:0] RM_RMM = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_ROUND = 2'd2,
        ST_HOLD  = 2'd3
    } state_e;

    localparam int FLAG_INEXACT   = 0;
    localparam int FLAG_OVERFLOW  = 1;
    localparam int FLAG_UNDERFLOW = 2;
    localparam int NFLAGS         = 3;

    function automatic logic round_up(input logic [2:0] rm, input logic sign,
                                      input logic g, input logic s, input logic lsb);
        case (rm)
            RM_RNE:  return g & (s | lsb);
            RM_RTZ:  return 1'b0;
            RM_RDN:  return sign & (g | s);
            RM_RUP:  return ~sign & (g | s);
            RM_RMM:  return g;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/fpdiv_normround_if.sv
// rtl/fpdiv_normround_if.sv - divider-to-normround capture bus and result handshake
interface fpdiv_normround_if #(
    parameter int FPWID = 112,
    parameter int OUTW  = 113,
    parameter int EXPW  = 15
);
    logic                 done_i;
    logic [2*FPWID-1:0]   q_i;
    logic [FPWID-1:0]     r_i;
    logic [7:0]           lzcnt_i;
    logic [EXPW+1:0]      exp_i;
    logic                 sign_i;
    logic [2:0]           rm_i;
    logic                 ready_i;

    logic                 valid_o;
    logic [OUTW-1:0]      man_o;
    logic [EXPW-1:0]      exp_o;
    logic                 sign_o;
    logic                 inexact_o;
    logic                 overflow_o;
    logic                 underflow_o;
    logic                 busy_o;
    logic                 drop_o;

    modport master (
        output done_i, q_i, r_i, lzcnt_i, exp_i, sign_i, rm_i, ready_i,
        input  valid_o, man_o, exp_o, sign_o, inexact_o, overflow_o, underflow_o, busy_o, drop_o
    );

    modport slave (
        input  done_i, q_i, r_i, lzcnt_i, exp_i, sign_i, rm_i, ready_i,
        output valid_o, man_o, exp_o, sign_o, inexact_o, overflow_o, underflow_o, busy_o, drop_o
    );
endinterface

// File: rtl/fpdiv_round.sv
// rtl/fpdiv_round.sv - combinational IEEE increment of a truncated mantissa; shared with sqrt
module fpdiv_round
    import fpdiv_pkg::*;
#(
    parameter int W = 113
) (
    input  logic [W-1:0] m_i,
    input  logic         g_i,
    input  logic         s_i,
    input  logic         sign_i,
    input  logic [2:0]   rm_i,
    output logic [W-1:0] m_o,
    output logic         carry_o,
    output logic         inexact_o
);
    logic         inc;
    logic [W:0]   sum;

    always_comb begin
        inc       = round_up(rm_i, sign_i, g_i, s_i, m_i[0]);
        sum       = {1'b0, m_i} + {{W{1'b0}}, inc};
        carry_o   = sum[W];
        // all-ones rounding up wraps to zero; renormalise to 1.000 and let the caller bump the exponent
        m_o       = carry_o ? {1'b1, {(W-1){1'b0}}} : sum[W-1:0];
        inexact_o = g_i | s_i;
    end
endmodule

// File: rtl/fpdiv_normround.sv
// rtl/fpdiv_normround.sv - normalise, round and range-check the divider quotient behind a valid/ready output
module fpdiv_normround
    import fpdiv_pkg::*;
#(
    parameter int FPWID = 112,
    parameter int OUTW  = 113,
    parameter int EXPW  = 15
) (
    input  logic              clk,
    input  logic              rst,
    fpdiv_normround_if.slave  bus
);
    localparam int QW  = 2 * FPWID;
    localparam int EW  = EXPW + 2;
    localparam int LOW = QW - OUTW - 1;
    localparam logic signed [EW:0] E_OVF = (EW+1)'((2 ** EXPW) - 1);

    state_e                 state_q;
    logic                   phase_q;
    logic [QW-1:0]          q_q;
    logic [FPWID-1:0]       r_q;
    logic [7:0]             lz_q;
    logic signed [EW-1:0]   e_q;
    logic                   sign_q;
    logic [2:0]             rm_q;
    logic                   zq_q;

    logic                   valid_q;
    logic [OUTW-1:0]        man_q;
    logic [EXPW-1:0]        expo_q;
    logic                   sign_out_q;
    logic [NFLAGS-1:0]      flags_q;
    logic                   drop_q;

    logic [OUTW-1:0]        m_rnd;
    logic                   carry;
    logic                   inx;
    logic                   sticky;
    logic signed [EW:0]     e_rnd;
    logic                   ovf;
    logic                   unf;
    logic                   to_inf;
    logic [OUTW-1:0]        man_d;
    logic [EXPW-1:0]        expo_d;
    logic [NFLAGS-1:0]      flags_d;
    logic                   accept;
    logic                   capture;

    assign sticky = (|q_q[LOW-1:0]) | (|r_q);

    fpdiv_round #(.W(OUTW)) u_round (
        .m_i       (q_q[QW-1 -: OUTW]),
        .g_i       (q_q[LOW]),
        .s_i       (sticky),
        .sign_i    (sign_q),
        .rm_i      (rm_q),
        .m_o       (m_rnd),
        .carry_o   (carry),
        .inexact_o (inx)
    );

    assign e_rnd  = $signed({e_q[EW-1], e_q}) + $signed({{EW{1'b0}}, carry});
    assign ovf    = (e_rnd >= E_OVF);
    assign unf    = e_rnd[EW] | (e_rnd == '0);
    assign to_inf = (rm_q == RM_RNE) | (rm_q == RM_RMM) |
                    ((rm_q == RM_RUP) & ~sign_q) | ((rm_q == RM_RDN) & sign_q);

    always_comb begin
        man_d                 = m_rnd;
        expo_d                = e_rnd[EXPW-1:0];
        flags_d               = '0;
        flags_d[FLAG_INEXACT] = inx;
        if (zq_q) begin
            man_d   = '0;
            expo_d  = '0;
            flags_d = '0;
        end else if (ovf) begin
            flags_d[FLAG_OVERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]  = 1'b1;
            man_d  = to_inf ? '0 : '1;
            expo_d = to_inf ? '1 : {{(EXPW-1){1'b1}}, 1'b0};
        end else if (unf) begin
            man_d   = '0;
            expo_d  = '0;
            flags_d[FLAG_UNDERFLOW] = 1'b1;
            flags_d[FLAG_INEXACT]   = 1'b1;
        end
    end

    assign accept  = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & bus.ready_i);
    assign capture = bus.done_i & accept;

    // The wide shifter is split into a radix-16 coarse step and a 0..15 fine step across two SHIFT cycles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            phase_q    <= 1'b0;
            q_q        <= '0;
            r_q        <= '0;
            lz_q       <= '0;
            e_q        <= '0;
            sign_q     <= 1'b0;
            rm_q       <= '0;
            zq_q       <= 1'b0;
            valid_q    <= 1'b0;
            man_q      <= '0;
            expo_q     <= '0;
            sign_out_q <= 1'b0;
            flags_q    <= '0;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= bus.done_i & ~accept;
            if (capture) begin
                q_q     <= bus.q_i;
                r_q     <= bus.r_i;
                lz_q    <= bus.lzcnt_i;
                e_q     <= $signed(bus.exp_i);
                sign_q  <= bus.sign_i;
                rm_q    <= bus.rm_i;
                zq_q    <= (bus.q_i == '0);
                phase_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (capture) state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!phase_q) begin
                        q_q     <= q_q << {lz_q[7:4], 4'b0000};
                        e_q     <= e_q - $signed({{(EW-8){1'b0}}, lz_q});
                        phase_q <= 1'b1;
                    end else begin
                        q_q     <= q_q << lz_q[3:0];
                        phase_q <= 1'b0;
                        state_q <= ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    man_q      <= man_d;
                    expo_q     <= expo_d;
                    sign_out_q <= sign_q;
                    flags_q    <= flags_d;
                    valid_q    <= 1'b1;
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (bus.ready_i) begin
                        valid_q <= 1'b0;
                        state_q <= capture ? ST_SHIFT : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.valid_o     = valid_q;
    assign bus.man_o       = man_q;
    assign bus.exp_o       = expo_q;
    assign bus.sign_o      = sign_out_q;
    assign bus.inexact_o   = flags_q[FLAG_INEXACT];
    assign bus.overflow_o  = flags_q[FLAG_OVERFLOW];
    assign bus.underflow_o = flags_q[FLAG_UNDERFLOW];
    assign bus.busy_o      = (state_q != ST_IDLE);
    assign bus.drop_o      = drop_q;
endmodule

// File: tb/tb_fpdiv_normround.sv
// tb/tb_fpdiv_normround.sv - randomized and directed check of fpdiv_normround against a value-level model
module tb_fpdiv_normround;
    localparam int FPWID = 12;
    localparam int OUTW  = 13;
    localparam int EXPW  = 8;

    typedef struct packed {
        logic [12:0] man;
        logic [7:0]  ex;
        logic        sg;
        logic        inx;
        logic        ovf;
        logic        unf;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fpdiv_normround_if #(.FPWID(FPWID), .OUTW(OUTW), .EXPW(EXPW)) bus();

    fpdiv_normround #(.FPWID(FPWID), .OUTW(OUTW), .EXPW(EXPW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t expq[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Value-level reference: scale the quotient, then round by comparing the discarded fraction with one half
    function automatic res_t model(input logic [23:0] q, input logic [11:0] r, input int lz,
                                   input int ex, input bit sg, input int rm);
        res_t   o;
        longint nq, m, rem;
        int     e;
        bit     above, tie, inx, up, to_inf;
        o    = '0;
        o.sg = sg;
        if (q == 0) return o;
        nq    = (longint'(q) << lz) & 64'hFF_FFFF;
        m     = nq >> 11;
        rem   = nq & 64'h7FF;
        above = (rem > 64'h400) || (rem == 64'h400 && r != 0);
        tie   = (rem == 64'h400) && (r == 0);
        inx   = (rem != 0) || (r != 0);
        case (rm)
            0:       up = above || (tie && (m % 2 == 1));
            1:       up = 1'b0;
            2:       up = sg && inx;
            3:       up = !sg && inx;
            default: up = above || tie;
        endcase
        e = ex - lz;
        m = m + longint'(up);
        if (m == 64'h2000) begin
            m = 64'h1000;
            e = e + 1;
        end
        if (e >= 255) begin
            to_inf = (rm == 0) || (rm == 4) || (rm == 3 && !sg) || (rm == 2 && sg);
            o.ovf  = 1'b1;
            o.inx  = 1'b1;
            o.man  = to_inf ? 13'h0000 : 13'h1FFF;
            o.ex   = to_inf ? 8'hFF : 8'hFE;
        end else if (e <= 0) begin
            o.unf = 1'b1;
            o.inx = 1'b1;
        end else begin
            o.man = 13'(m);
            o.ex  = 8'(e);
            o.inx = inx;
        end
        return o;
    endfunction

    function automatic int clz24(input logic [23:0] q);
        int n = 0;
        for (int i = 23; i >= 0; i--) begin
            if (q[i]) return n;
            n++;
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.valid_o === 1'b1) begin
            if (expq.size() == 0) begin
                check("unexpected_valid", 64'(bus.valid_o), 64'd0);
            end else begin
                check("man",       64'(bus.man_o),       64'(expq[0].man));
                check("exp",       64'(bus.exp_o),       64'(expq[0].ex));
                check("sign",      64'(bus.sign_o),      64'(expq[0].sg));
                check("inexact",   64'(bus.inexact_o),   64'(expq[0].inx));
                check("overflow",  64'(bus.overflow_o),  64'(expq[0].ovf));
                check("underflow", 64'(bus.underflow_o), 64'(expq[0].unf));
                if (bus.ready_i) void'(expq.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [23:0] q, input logic [11:0] r, input int lz, input int ex,
                         input bit sg, input int rm, input bit push);
        bus.q_i     = q;
        bus.r_i     = r;
        bus.lzcnt_i = lz[7:0];
        bus.exp_i   = ex[9:0];
        bus.sign_i  = sg;
        bus.rm_i    = rm[2:0];
        bus.done_i  = 1'b1;
        if (push) expq.push_back(model(q, r, lz, ex, sg, rm));
        tick();
        bus.done_i  = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (bus.valid_o !== 1'b1 && k < 12) begin
            tick();
            k++;
        end
        check(name, 64'(bus.valid_o), 64'd1);
    endtask

    task automatic lat_vec(input logic [23:0] q, input logic [11:0] r, input int lz, input int ex,
                           input bit sg, input int rm);
        bus.ready_i = 1'b1;
        drive(q, r, lz, ex, sg, rm, 1'b1);
        check("busy_after_done", 64'(bus.busy_o), 64'd1);
        tick();
        check("valid_n1", 64'(bus.valid_o), 64'd0);
        tick();
        check("valid_n2", 64'(bus.valid_o), 64'd0);
        tick();
        check("valid_n3", 64'(bus.valid_o), 64'd1);
        tick();
        check("valid_fall", 64'(bus.valid_o), 64'd0);
        check("busy_idle", 64'(bus.busy_o), 64'd0);
    endtask

    task automatic pin(input string name, input res_t got, input logic [12:0] man, input logic [7:0] ex,
                       input bit inx, input bit ovf, input bit unf);
        check({name, "_man"}, 64'(got.man), 64'(man));
        check({name, "_exp"}, 64'(got.ex),  64'(ex));
        check({name, "_flags"}, 64'({got.inx, got.ovf, got.unf}), 64'({inx, ovf, unf}));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: actual running required finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [23:0] q;
        logic [11:0] r;
        int          lz, ex, rm;
        bit          sg, in_hold;

        bus.done_i = 1'b0; bus.q_i = '0; bus.r_i = '0; bus.lzcnt_i = '0;
        bus.exp_i = '0; bus.sign_i = 1'b0; bus.rm_i = '0; bus.ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.valid_o), 64'd0);
        check("rst_busy",  64'(bus.busy_o),  64'd0);
        check("rst_drop",  64'(bus.drop_o),  64'd0);
        check("rst_man",   64'(bus.man_o),   64'd0);
        check("rst_exp",   64'(bus.exp_o),   64'd0);
        check("rst_flags", 64'({bus.inexact_o, bus.overflow_o, bus.underflow_o}), 64'd0);
        rst = 1'b0;
        tick();

        pin("m1", model(24'h600000, 12'd0, 1, 130, 1'b0, 0), 13'h1800, 8'd129, 0, 0, 0);
        pin("m2", model(24'hFFFC00, 12'd0, 0, 100, 1'b0, 0), 13'h1000, 8'd101, 1, 0, 0);
        pin("m3", model(24'hFFFC00, 12'd0, 0, 100, 1'b0, 1), 13'h1FFF, 8'd100, 1, 0, 0);
        pin("m4", model(24'hFFFC00, 12'd1, 0, 100, 1'b1, 2), 13'h1000, 8'd101, 1, 0, 0);
        pin("m5", model(24'h800000, 12'd0, 0, 255, 1'b0, 0), 13'h0000, 8'hFF, 1, 1, 0);
        pin("m6", model(24'h800000, 12'd0, 0, 255, 1'b0, 1), 13'h1FFF, 8'hFE, 1, 1, 0);
        pin("m7", model(24'h100000, 12'd0, 3, 3, 1'b0, 0),   13'h0000, 8'd0,  1, 0, 1);
        pin("m8", model(24'h000000, 12'd0, 0, 100, 1'b0, 0), 13'h0000, 8'd0,  0, 0, 0);

        lat_vec(24'h600000, 12'd0, 1, 130, 1'b0, 0);
        lat_vec(24'hFFFC00, 12'd0, 0, 100, 1'b0, 0);
        lat_vec(24'hFFFC00, 12'd0, 0, 100, 1'b0, 1);
        lat_vec(24'hFFFC00, 12'd1, 0, 100, 1'b1, 2);
        lat_vec(24'h800000, 12'd0, 0, 255, 1'b0, 0);
        lat_vec(24'h800000, 12'd0, 0, 255, 1'b0, 1);
        lat_vec(24'h100000, 12'd0, 3, 3, 1'b0, 0);
        lat_vec(24'h000000, 12'd0, 0, 100, 1'b0, 0);

        // Stall, drop while held, then accept a new done in the same cycle as ready
        bus.ready_i = 1'b0;
        drive(24'hABCDE0, 12'h005, 0, 120, 1'b1, 4, 1'b1);
        wait_valid("hold_valid");
        repeat (5) tick();
        drive(24'h123456, 12'd0, 3, 90, 1'b0, 0, 1'b0);
        check("drop_in_hold", 64'(bus.drop_o), 64'd1);
        check("valid_kept",   64'(bus.valid_o), 64'd1);
        tick();
        check("drop_one_cycle", 64'(bus.drop_o), 64'd0);
        bus.ready_i = 1'b1;
        drive(24'h0F0F0F, 12'd0, 4, 60, 1'b0, 3, 1'b1);
        check("b2b_valid_fall", 64'(bus.valid_o), 64'd0);
        check("b2b_busy", 64'(bus.busy_o), 64'd1);
        tick();
        tick();
        check("b2b_n2", 64'(bus.valid_o), 64'd0);
        tick();
        check("b2b_n3", 64'(bus.valid_o), 64'd1);
        tick();

        drive(24'h400001, 12'd0, 1, 50, 1'b0, 0, 1'b1);
        drive(24'h222222, 12'd0, 2, 50, 1'b0, 0, 1'b0);
        check("drop_in_shift", 64'(bus.drop_o), 64'd1);
        wait_valid("after_shift_drop");
        tick();

        drive(24'h600000, 12'd0, 1, 130, 1'b0, 0, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_busy_async", 64'(bus.busy_o), 64'd0);
        expq.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no_valid_after_rst", 64'(bus.valid_o), 64'd0);
        end
        lat_vec(24'h7FF800, 12'd0, 1, 200, 1'b1, 0);

        in_hold = 1'b0;
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(0, 9) == 0) begin
                q  = '0;
                lz = 0;
            end else begin
                q = 24'($urandom) >> $urandom_range(0, 20);
                if (q == 0) q = 24'd1;
                if ($urandom_range(0, 3) == 0) q = q & ~(24'h3FF >> clz24(q));
                lz = clz24(q);
            end
            r  = ($urandom_range(0, 1) == 0) ? 12'd0 : 12'($urandom);
            case ($urandom_range(0, 3))
                0:       ex = lz + $urandom_range(0, 2);
                1:       ex = lz + 253 + $urandom_range(0, 3);
                default: ex = $urandom_range(0, 320) - 20;
            endcase
            sg = 1'($urandom);
            rm = $urandom_range(0, 4);
            if (in_hold) bus.ready_i = 1'b1;
            drive(q, r, lz, ex, sg, rm, 1'b1);
            bus.ready_i = 1'b0;
            wait_valid("rand_valid");
            repeat ($urandom_range(0, 3)) tick();
            if ($urandom_range(0, 1) == 1) begin
                in_hold = 1'b1;
            end else begin
                in_hold = 1'b0;
                bus.ready_i = 1'b1;
                tick();
            end
        end
        bus.ready_i = 1'b1;
        tick();
        tick();
        check("drain_queue", 64'(expq.size()), 64'd0);
        check("drain_valid", 64'(bus.valid_o), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
